culsans_sram_arbiter: RTL and testbench

Shares the single-port on-chip SRAM of `culsans_top` between `NumPorts` requesters, such as the per-core memory paths. It grants one request per cycle using round-robin order and returns read data one cycle after the grant. An optional preload phase gives a loader exclusive access before the cores start.

---
 rtl/culsans_sram_arbiter.sv | 152 +++++++++++++++
 tb/tb_culsans_sram_arbiter.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/culsans_sram_arbiter.sv
// Round-robin arbiter sharing one single-port SRAM between NumPorts requesters.
// Latency: grant is combinational; read data and rvalid follow one cycle after the grant.
// Backpressure: an ungranted requester holds req/payload; one access per cycle, optional preload owns SRAM first.
// Optional feature macro: CULSANS_SRAM_ARB_PRELOAD_EN (adds preload ports and a PRELOAD state after reset).
module culsans_sram_arbiter #(
    parameter int unsigned NumPorts  = 2,
    parameter int unsigned AddrWidth = 32,
    parameter int unsigned DataWidth = 64,
    localparam int unsigned BeWidth  = DataWidth / 8
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,
    input  logic [NumPorts-1:0]                 req_i,
    input  logic [NumPorts-1:0]                 we_i,
    input  logic [NumPorts-1:0][AddrWidth-1:0]  addr_i,
    input  logic [NumPorts-1:0][DataWidth-1:0]  wdata_i,
    input  logic [NumPorts-1:0][BeWidth-1:0]    be_i,
    output logic [NumPorts-1:0]                 gnt_o,
    output logic [NumPorts-1:0]                 rvalid_o,
    output logic [DataWidth-1:0]                rdata_o,
    output logic                                sram_req_o,
    output logic                                sram_we_o,
    output logic [AddrWidth-1:0]                sram_addr_o,
    output logic [DataWidth-1:0]                sram_wdata_o,
    output logic [BeWidth-1:0]                  sram_be_o,
    input  logic [DataWidth-1:0]                sram_rdata_i,
`ifdef CULSANS_SRAM_ARB_PRELOAD_EN
    input  logic                                pl_req_i,
    input  logic [AddrWidth-1:0]                pl_addr_i,
    input  logic [DataWidth-1:0]                pl_wdata_i,
    input  logic [BeWidth-1:0]                  pl_be_i,
    output logic                                pl_gnt_o,
    input  logic                                pl_done_i,
`endif
    output logic                                ready_o
);

    localparam int unsigned PtrW = (NumPorts > 1) ? $clog2(NumPorts) : 1;

    typedef enum logic {
        ST_PRELOAD = 1'b0,
        ST_RUN     = 1'b1
    } state_e;

`ifdef CULSANS_SRAM_ARB_PRELOAD_EN
    localparam state_e StReset = ST_PRELOAD;
`else
    localparam state_e StReset = ST_RUN;
`endif

    state_e              r_state;
    state_e              w_state_nxt;
    logic [PtrW-1:0]     r_rr;
    logic [PtrW-1:0]     w_rr_nxt;
    logic [PtrW-1:0]     w_sel;
    logic                w_hit;
    logic [NumPorts-1:0] w_gnt;
    logic [NumPorts-1:0] r_rvalid;

    // Round-robin search: first requesting port at or after r_rr, wrapping modulo NumPorts.
    always_comb begin
        logic [PtrW:0] v_idx;
        w_hit = 1'b0;
        w_sel = '0;
        w_gnt = '0;
        v_idx = '0;
        if (rst_ni && (r_state == ST_RUN)) begin
            for (int i = 0; i < NumPorts; i++) begin
                v_idx = {1'b0, r_rr} + (PtrW+1)'(i);
                if (v_idx >= (PtrW+1)'(NumPorts)) begin
                    v_idx = v_idx - (PtrW+1)'(NumPorts);
                end
                if (!w_hit && req_i[v_idx[PtrW-1:0]]) begin
                    w_hit = 1'b1;
                    w_sel = v_idx[PtrW-1:0];
                end
            end
        end
        if (w_hit) begin
            w_gnt[w_sel] = 1'b1;
        end
    end

    // Pointer moves just past the winner; it holds when nobody is granted.
    always_comb begin
        w_rr_nxt = r_rr;
        if (w_hit) begin
            w_rr_nxt = (w_sel == PtrW'(NumPorts - 1)) ? '0 : w_sel + PtrW'(1);
        end
    end

    // SRAM command mux: granted core port in RUN, loader in PRELOAD, zeros when idle.
    always_comb begin
        sram_req_o   = 1'b0;
        sram_we_o    = 1'b0;
        sram_addr_o  = '0;
        sram_wdata_o = '0;
        sram_be_o    = '0;
`ifdef CULSANS_SRAM_ARB_PRELOAD_EN
        pl_gnt_o     = 1'b0;
`endif
        if (w_hit) begin
            sram_req_o   = 1'b1;
            sram_we_o    = we_i[w_sel];
            sram_addr_o  = addr_i[w_sel];
            sram_wdata_o = wdata_i[w_sel];
            sram_be_o    = be_i[w_sel];
        end
`ifdef CULSANS_SRAM_ARB_PRELOAD_EN
        else if (rst_ni && (r_state == ST_PRELOAD) && pl_req_i) begin
            pl_gnt_o     = 1'b1;
            sram_req_o   = 1'b1;
            sram_we_o    = 1'b1;
            sram_addr_o  = pl_addr_i;
            sram_wdata_o = pl_wdata_i;
            sram_be_o    = pl_be_i;
        end
`endif
    end

    // PRELOAD leaves for RUN once the loader signals done; RUN is absorbing.
    always_comb begin
        w_state_nxt = r_state;
`ifdef CULSANS_SRAM_ARB_PRELOAD_EN
        if ((r_state == ST_PRELOAD) && pl_done_i) begin
            w_state_nxt = ST_RUN;
        end
`else
        w_state_nxt = ST_RUN;
`endif
    end

    // State, pointer and read-valid pipeline registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state  <= StReset;
            r_rr     <= '0;
            r_rvalid <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_rr     <= w_rr_nxt;
            r_rvalid <= w_gnt & ~we_i;
        end
    end

    // A read in flight when reset asserts is dropped immediately.
    assign gnt_o    = w_gnt;
    assign rvalid_o = r_rvalid & {NumPorts{rst_ni}};
    assign rdata_o  = sram_rdata_i;
    assign ready_o  = (r_state == ST_RUN);

endmodule

// File: tb/tb_culsans_sram_arbiter.sv
// Self-checking bench for culsans_sram_arbiter with an SRAM model and a round-robin reference model.
// Latency: checks combinational grants each cycle and rvalid/rdata one cycle later.
// Backpressure: random requesters hold payload until granted.
module tb_culsans_sram_arbiter;

    localparam int N  = 2;
    localparam int AW = 32;
    localparam int DW = 64;
    localparam int BW = 8;
`ifdef CULSANS_SRAM_ARB_PRELOAD_EN
    localparam bit PL_EN = 1'b1;
`else
    localparam bit PL_EN = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                   rst_ni = 1'b0;
    logic [N-1:0]           req    = '0;
    logic [N-1:0]           we     = '0;
    logic [N-1:0][AW-1:0]   addr   = '0;
    logic [N-1:0][DW-1:0]   wdata  = '0;
    logic [N-1:0][BW-1:0]   be     = '0;
    logic [N-1:0]           gnt_o, rvalid_o;
    logic [DW-1:0]          rdata_o;
    logic                   sram_req_o, sram_we_o;
    logic [AW-1:0]          sram_addr_o;
    logic [DW-1:0]          sram_wdata_o;
    logic [BW-1:0]          sram_be_o;
    logic [DW-1:0]          sram_rdata = '0;
    logic                   ready_o;
`ifdef CULSANS_SRAM_ARB_PRELOAD_EN
    logic                   pl_req   = 1'b0;
    logic [AW-1:0]          pl_addr  = '0;
    logic [DW-1:0]          pl_wdata = '0;
    logic [BW-1:0]          pl_be    = '0;
    logic                   pl_done  = 1'b0;
    logic                   pl_gnt_o;
`endif

    culsans_sram_arbiter #(.NumPorts(N), .AddrWidth(AW), .DataWidth(DW)) dut (
        .clk_i(clk), .rst_ni(rst_ni), .req_i(req), .we_i(we), .addr_i(addr),
        .wdata_i(wdata), .be_i(be), .gnt_o(gnt_o), .rvalid_o(rvalid_o), .rdata_o(rdata_o),
        .sram_req_o(sram_req_o), .sram_we_o(sram_we_o), .sram_addr_o(sram_addr_o),
        .sram_wdata_o(sram_wdata_o), .sram_be_o(sram_be_o), .sram_rdata_i(sram_rdata),
`ifdef CULSANS_SRAM_ARB_PRELOAD_EN
        .pl_req_i(pl_req), .pl_addr_i(pl_addr), .pl_wdata_i(pl_wdata), .pl_be_i(pl_be),
        .pl_gnt_o(pl_gnt_o), .pl_done_i(pl_done),
`endif
        .ready_o(ready_o)
    );

    int errors = 0;
    int checks = 0;

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old_v, input logic [DW-1:0] new_v,
                                            input logic [BW-1:0] bes);
        logic [DW-1:0] r;
        r = old_v;
        for (int b = 0; b < BW; b++) if (bes[b]) r[8*b +: 8] = new_v[8*b +: 8];
        return r;
    endfunction

    // SRAM macro model driven purely by the DUT's SRAM port.
    logic [DW-1:0] sram_mem [0:255];
    initial for (int i = 0; i < 256; i++) sram_mem[i] = '0;
    always @(posedge clk) begin
        if (sram_req_o) begin
            if (sram_we_o) sram_mem[sram_addr_o[7:0]] <= merge(sram_mem[sram_addr_o[7:0]], sram_wdata_o, sram_be_o);
            else           sram_rdata <= sram_mem[sram_addr_o[7:0]];
        end
    end

    // Reference model: pointer as integer, expected memory contents, pending read.
    int            m_rr  = 0;
    logic [N-1:0]  m_rv  = '0;
    logic [DW-1:0] m_rdata = '0;
    bit            m_run = 1'b0;
    logic [DW-1:0] exp_mem [0:255];
    initial for (int i = 0; i < 256; i++) exp_mem[i] = '0;

    function automatic logic [N-1:0] exp_gnt_f();
        logic [N-1:0] g;
        int p;
        g = '0;
        if (rst_ni && m_run) begin
            for (int i = 0; i < N; i++) begin
                p = (m_rr + i) % N;
                if (req[p] && g == '0) g[p] = 1'b1;
            end
        end
        return g;
    endfunction

    // Advance the model by the clock edge that follows the current inputs.
    task automatic model_step();
        logic [N-1:0] g;
        g = exp_gnt_f();
        if (!rst_ni) begin
            m_rr = 0; m_rv = '0; m_run = !PL_EN;
            return;
        end
        m_rv = '0;
        for (int k = 0; k < N; k++) begin
            if (g[k]) begin
                m_rr = (k + 1) % N;
                if (we[k]) exp_mem[addr[k][7:0]] = merge(exp_mem[addr[k][7:0]], wdata[k], be[k]);
                else begin m_rv[k] = 1'b1; m_rdata = exp_mem[addr[k][7:0]]; end
            end
        end
`ifdef CULSANS_SRAM_ARB_PRELOAD_EN
        if (!m_run) begin
            if (pl_req) exp_mem[pl_addr[7:0]] = merge(exp_mem[pl_addr[7:0]], pl_wdata, pl_be);
            if (pl_done) m_run = 1'b1;
        end
`endif
    endtask

    task automatic enter_reset();
        @(negedge clk); rst_ni = 1'b0; req = '0; #1; model_step();
    endtask

    task automatic do_reset();
        enter_reset();
        @(negedge clk); rst_ni = 1'b1; req = '0;
`ifdef CULSANS_SRAM_ARB_PRELOAD_EN
        pl_req = 1'b0; pl_done = 1'b1;
`endif
        #1; model_step();
`ifdef CULSANS_SRAM_ARB_PRELOAD_EN
        @(negedge clk); pl_done = 1'b0; #1; model_step();
`endif
    endtask

    task automatic test_reset();
        for (int c = 0; c < 2; c++) begin
            @(negedge clk); rst_ni = 1'b0; req = 2'b11; we = 2'b00; #1;
            checks++; if (gnt_o !== 2'b00) begin errors++; $display("FAIL rst_gnt: got %b want 00", gnt_o); end
            checks++; if (sram_req_o !== 1'b0) begin errors++; $display("FAIL rst_sram_req: got %b want 0", sram_req_o); end
            checks++; if (rvalid_o !== 2'b00) begin errors++; $display("FAIL rst_rvalid: got %b want 00", rvalid_o); end
            model_step();
        end
        @(negedge clk); rst_ni = 1'b1; req = '0;
`ifdef CULSANS_SRAM_ARB_PRELOAD_EN
        pl_done = 1'b1;
`endif
        #1;
        checks++; if (ready_o !== m_run) begin errors++; $display("FAIL rst_ready: got %b want %b", ready_o, m_run); end
        model_step();
        @(negedge clk); req = 2'b11;
`ifdef CULSANS_SRAM_ARB_PRELOAD_EN
        pl_done = 1'b0;
`endif
        #1;
        checks++; if (gnt_o !== 2'b01) begin errors++; $display("FAIL rst_first_gnt: got %b want 01", gnt_o); end
        checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL run_ready: got %b want 1", ready_o); end
        model_step();
    endtask

    task automatic test_write_read();
        @(negedge clk); req = 2'b01; we = 2'b01; addr[0] = 32'h10; wdata[0] = 64'hDEAD_BEEF; be[0] = 8'hFF; #1;
        checks++; if (gnt_o !== 2'b01) begin errors++; $display("FAIL wr_gnt: got %b want 01", gnt_o); end
        checks++; if ({sram_req_o, sram_we_o, sram_addr_o, sram_wdata_o} !== {1'b1, 1'b1, 32'h10, 64'hDEAD_BEEF})
            begin errors++; $display("FAIL wr_sram: got we=%b a=%h d=%h want we=1 a=10 d=deadbeef", sram_we_o, sram_addr_o, sram_wdata_o); end
        model_step();
        @(negedge clk); we = 2'b00; #1;
        checks++; if (gnt_o !== 2'b01) begin errors++; $display("FAIL rd_gnt: got %b want 01", gnt_o); end
        checks++; if (rvalid_o !== 2'b00) begin errors++; $display("FAIL wr_no_rvalid: got %b want 00", rvalid_o); end
        model_step();
        @(negedge clk); req = 2'b00; #1;
        checks++; if (rvalid_o !== 2'b01) begin errors++; $display("FAIL rd_rvalid: got %b want 01", rvalid_o); end
        checks++; if (rdata_o !== 64'hDEAD_BEEF) begin errors++; $display("FAIL rd_data: got %h want deadbeef", rdata_o); end
        model_step();
    endtask

    task automatic test_alternate();
        logic [N-1:0] want, prev;
        do_reset();
        prev = '0;
        for (int c = 0; c < 7; c++) begin
            @(negedge clk); req = (c < 6) ? 2'b11 : 2'b00; we = 2'b00; addr[0] = 32'h10; addr[1] = 32'h20; #1;
            want = (c >= 6) ? 2'b00 : ((c % 2 == 0) ? 2'b01 : 2'b10);
            checks++; if (gnt_o !== want) begin errors++; $display("FAIL alt_gnt[%0d]: got %b want %b", c, gnt_o, want); end
            checks++; if (rvalid_o !== prev) begin errors++; $display("FAIL alt_rvalid[%0d]: got %b want %b", c, rvalid_o, prev); end
            prev = want;
            model_step();
        end
    endtask

    task automatic test_single_then_both();
        for (int c = 0; c < 4; c++) begin
            @(negedge clk); req = (c < 3) ? 2'b10 : 2'b11; we = 2'b00; #1;
            checks++; if (gnt_o !== ((c < 3) ? 2'b10 : 2'b01))
                begin errors++; $display("FAIL single_gnt[%0d]: got %b want %b", c, gnt_o, (c < 3) ? 2'b10 : 2'b01); end
            model_step();
        end
    endtask

    task automatic test_reset_mid_read();
        @(negedge clk); req = 2'b10; we = 2'b00; #1;
        checks++; if (gnt_o !== 2'b10) begin errors++; $display("FAIL mid_gnt: got %b want 10", gnt_o); end
        model_step();
        @(negedge clk); rst_ni = 1'b0; req = 2'b11; #1;
        checks++; if (rvalid_o !== 2'b00) begin errors++; $display("FAIL mid_rvalid: got %b want 00", rvalid_o); end
        checks++; if (gnt_o !== 2'b00) begin errors++; $display("FAIL mid_rst_gnt: got %b want 00", gnt_o); end
        model_step();
        @(negedge clk); rst_ni = 1'b1; req = 2'b00;
`ifdef CULSANS_SRAM_ARB_PRELOAD_EN
        pl_done = 1'b1;
`endif
        #1;
        checks++; if (rvalid_o !== 2'b00) begin errors++; $display("FAIL mid_after_rvalid: got %b want 00", rvalid_o); end
        model_step();
        @(negedge clk); req = 2'b11;
`ifdef CULSANS_SRAM_ARB_PRELOAD_EN
        pl_done = 1'b0;
`endif
        #1;
        checks++; if (gnt_o !== 2'b01) begin errors++; $display("FAIL mid_first_gnt: got %b want 01", gnt_o); end
        model_step();
    endtask

    task automatic test_random();
        logic [N-1:0] lastg, g;
        int k;
        lastg = '1;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            for (int p = 0; p < N; p++) begin
                if (!req[p] || lastg[p]) begin
                    req[p]   = ($urandom_range(0, 3) != 0);
                    we[p]    = 1'($urandom_range(0, 1));
                    addr[p]  = AW'($urandom_range(0, 7));
                    wdata[p] = {$urandom, $urandom};
                    be[p]    = BW'($urandom);
                end
            end
            #1;
            g = exp_gnt_f();
            k = -1;
            for (int p = 0; p < N; p++) if (g[p]) k = p;
            checks++; if (gnt_o !== g) begin errors++; $display("FAIL rnd_gnt[%0d]: got %b want %b", c, gnt_o, g); end
            checks++;
            if (k < 0) begin
                if ({sram_req_o, sram_we_o, sram_addr_o, sram_wdata_o, sram_be_o} !== '0)
                    begin errors++; $display("FAIL rnd_sram_idle[%0d]: got req=%b a=%h want all zero", c, sram_req_o, sram_addr_o); end
            end else if ({sram_req_o, sram_we_o, sram_addr_o, sram_wdata_o, sram_be_o} !==
                         {1'b1, we[k], addr[k], wdata[k], be[k]}) begin
                errors++; $display("FAIL rnd_sram[%0d]: got we=%b a=%h d=%h be=%h want port %0d we=%b a=%h d=%h be=%h",
                                   c, sram_we_o, sram_addr_o, sram_wdata_o, sram_be_o, k, we[k], addr[k], wdata[k], be[k]);
            end
            checks++; if (rvalid_o !== m_rv) begin errors++; $display("FAIL rnd_rvalid[%0d]: got %b want %b", c, rvalid_o, m_rv); end
            if (m_rv != '0) begin
                checks++; if (rdata_o !== m_rdata) begin errors++; $display("FAIL rnd_rdata[%0d]: got %h want %h", c, rdata_o, m_rdata); end
            end
            lastg = g;
            model_step();
        end
        @(negedge clk); req = '0; #1; model_step();
    endtask

`ifdef CULSANS_SRAM_ARB_PRELOAD_EN
    task automatic test_preload();
        logic [DW-1:0] d [0:3];
        enter_reset();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); rst_ni = 1'b1; req = 2'b11; we = 2'b00;
            pl_req = 1'b1; pl_addr = 32'h40 + i; d[i] = {$urandom, $urandom}; pl_wdata = d[i]; pl_be = 8'hFF; #1;
            checks++; if (gnt_o !== 2'b00) begin errors++; $display("FAIL pl_gnt_core[%0d]: got %b want 00", i, gnt_o); end
            checks++; if (ready_o !== 1'b0) begin errors++; $display("FAIL pl_ready[%0d]: got %b want 0", i, ready_o); end
            checks++; if ({pl_gnt_o, sram_req_o, sram_we_o, sram_addr_o} !== {3'b111, 32'h40 + i})
                begin errors++; $display("FAIL pl_write[%0d]: got pg=%b req=%b we=%b a=%h", i, pl_gnt_o, sram_req_o, sram_we_o, sram_addr_o); end
            model_step();
        end
        @(negedge clk); pl_req = 1'b0; pl_done = 1'b1; #1;
        checks++; if (ready_o !== 1'b0 || gnt_o !== 2'b00) begin errors++; $display("FAIL pl_done_cycle: got ready=%b gnt=%b want 0/00", ready_o, gnt_o); end
        model_step();
        @(negedge clk); pl_done = 1'b0; req = 2'b01; addr[0] = 32'h42; #1;
        checks++; if (ready_o !== 1'b1 || gnt_o !== 2'b01) begin errors++; $display("FAIL pl_run: got ready=%b gnt=%b want 1/01", ready_o, gnt_o); end
        model_step();
        @(negedge clk); req = 2'b00; #1;
        checks++; if (rvalid_o !== 2'b01 || rdata_o !== d[2]) begin errors++; $display("FAIL pl_readback: got v=%b d=%h want 01/%h", rvalid_o, rdata_o, d[2]); end
        model_step();
    endtask

    task automatic test_pl_same_cycle();
        enter_reset();
        @(negedge clk); rst_ni = 1'b1; pl_req = 1'b1; pl_done = 1'b1; pl_addr = 32'h50; pl_wdata = 64'h1234; #1;
        checks++; if (pl_gnt_o !== 1'b1 || ready_o !== 1'b0) begin errors++; $display("FAIL pl_same_gnt: got pg=%b ready=%b want 1/0", pl_gnt_o, ready_o); end
        model_step();
        @(negedge clk); pl_done = 1'b0; #1;
        checks++; if (ready_o !== 1'b1 || pl_gnt_o !== 1'b0) begin errors++; $display("FAIL pl_same_run: got ready=%b pg=%b want 1/0", ready_o, pl_gnt_o); end
        model_step();
        @(negedge clk); pl_req = 1'b0; #1; model_step();
    endtask
`endif

    initial begin
        test_reset();
        test_write_read();
        test_alternate();
        test_single_then_both();
        test_reset_mid_read();
        test_random();
`ifdef CULSANS_SRAM_ARB_PRELOAD_EN
        test_preload();
        test_pl_same_cycle();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
